// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control sequencer: owns PC, IR and FSM, and drives
// register-file, ALU, RAM and writeback-mux controls of the single-cycle datapath.
module multicycle_ctrl #(
  parameter int unsigned          Data_Width            = 32,
  parameter int unsigned          Address_Width_RegFile = 5,
  parameter logic [Data_Width-1:0] RESET_PC             = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Data_Width-1:0]            instr,
  input  logic                             eq,
  output logic [Data_Width-1:0]            pc,
  output logic [Address_Width_RegFile-1:0] rs1,
  output logic [Address_Width_RegFile-1:0] rs2,
  output logic [Address_Width_RegFile-1:0] rd,
  output logic                             regFileWen,
  output logic                             ALUSrc,
  output logic [Data_Width-1:0]            ImmOp,
  output logic [3:0]                       ALU_ctrl,
  output logic                             MemWrite,
  output logic [1:0]                       dataType,
  output logic                             SrcSel,
  output logic [Data_Width-1:0]            newPC,
  output logic                             JumpSel,
  output logic                             trigger,
  output logic                             halt,
  output logic [Data_Width-1:0]            retired
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_BYTE = 2'b01;

  localparam logic [Data_Width-1:0] NOP_INSTR = Data_Width'(32'h0000_0013);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LUI, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_ILL
  } kind_t;

  state_t state_q, state_d;
  kind_t  kind;

  logic [Data_Width-1:0] ir;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [Data_Width-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic                  is_bne;

  logic                  wen_c, mwr_c;
  logic                  last_c, taken_c, halt_set_c;
  logic [Data_Width-1:0] pc_next;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign imm_i = {{(Data_Width-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(Data_Width-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(Data_Width-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(Data_Width-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = Data_Width'({ir[31:12], 12'b0});

  assign rs2     = ir[24:20];
  assign rd      = ir[11:7];
  assign newPC   = pc + Data_Width'(4);
  assign trigger = 1'b1;

  // Instruction decode: field-level controls depend only on IR.
  always_comb begin
    kind     = K_ILL;
    rs1      = ir[19:15];
    ImmOp    = '0;
    ALUSrc   = 1'b0;
    ALU_ctrl = ALU_ADD;
    dataType = DT_WORD;
    is_bne   = 1'b0;
    unique case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          kind = K_ALU;
          case (funct3)
            3'b000:  ALU_ctrl = ALU_ADD;
            3'b111:  ALU_ctrl = ALU_AND;
            3'b110:  ALU_ctrl = ALU_OR;
            3'b100:  ALU_ctrl = ALU_XOR;
            3'b001:  ALU_ctrl = ALU_SLL;
            3'b101:  ALU_ctrl = ALU_SRL;
            default: kind     = K_ILL;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          kind     = K_ALU;
          ALU_ctrl = ALU_SUB;
        end
      end
      OP_I: begin
        if (funct3 == 3'b000) begin
          kind   = K_ALU;
          ALUSrc = 1'b1;
          ImmOp  = imm_i;
        end
      end
      OP_LUI: begin
        kind   = K_LUI;
        rs1    = '0;
        ALUSrc = 1'b1;
        ImmOp  = imm_u;
      end
      OP_LOAD: begin
        ALUSrc = 1'b1;
        ImmOp  = imm_i;
        if (funct3 == 3'b010) begin
          kind = K_LOAD;
        end else if (funct3 == 3'b100) begin
          kind     = K_LOAD;
          dataType = DT_BYTE;
        end
      end
      OP_STORE: begin
        ALUSrc = 1'b1;
        ImmOp  = imm_s;
        if (funct3 == 3'b010) begin
          kind = K_STORE;
        end else if (funct3 == 3'b000) begin
          kind     = K_STORE;
          dataType = DT_BYTE;
        end
      end
      OP_BRANCH: begin
        ALU_ctrl = ALU_SUB;
        ImmOp    = imm_b;
        if (funct3 == 3'b000) begin
          kind = K_BRANCH;
        end else if (funct3 == 3'b001) begin
          kind   = K_BRANCH;
          is_bne = 1'b1;
        end
      end
      OP_JAL: begin
        kind  = K_JAL;
        ImmOp = imm_j;
      end
      default: kind = K_ILL;
    endcase
  end

  // Next-state and per-state enables.
  always_comb begin
    state_d    = state_q;
    wen_c      = 1'b0;
    mwr_c      = 1'b0;
    SrcSel     = 1'b0;
    JumpSel    = 1'b0;
    last_c     = 1'b0;
    taken_c    = 1'b0;
    halt_set_c = 1'b0;
    unique case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (kind == K_ILL) begin
          state_d    = HALT;
          halt_set_c = 1'b1;
        end else if (kind == K_JAL) begin
          state_d = WB;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (kind == K_LOAD || kind == K_STORE) begin
          state_d = MEM;
        end else if (kind == K_BRANCH) begin
          state_d = FETCH;
          last_c  = 1'b1;
          taken_c = is_bne ? !eq : eq;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (kind == K_LOAD) begin
          state_d = WB;
        end else begin
          state_d = FETCH;
          mwr_c   = 1'b1;
          last_c  = 1'b1;
        end
      end
      WB: begin
        state_d = FETCH;
        wen_c   = 1'b1;
        SrcSel  = (kind == K_LOAD);
        JumpSel = (kind == K_JAL);
        last_c  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // A reset arriving mid-instruction must suppress that cycle's write.
  assign regFileWen = wen_c && !rst;
  assign MemWrite   = mwr_c && !rst;

  always_comb begin
    pc_next = newPC;
    if (kind == K_JAL) begin
      pc_next = pc + imm_j;
    end else if (taken_c) begin
      pc_next = pc + imm_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, IR, halt flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= NOP_INSTR;
      halt    <= 1'b0;
      retired <= '0;
    end else begin
      if (state_q == FETCH) begin
        ir <= instr;
      end
      if (last_c) begin
        pc      <= pc_next;
        retired <= retired + Data_Width'(1);
      end
      if (halt_set_c) begin
        halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: small ROM program driven cycle by cycle,
// with hand-computed expectations for every control output checked.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic        eq = 1'b0;
  logic [31:0] pc;
  logic [4:0]  rs1, rs2, rd;
  logic        regFileWen, ALUSrc, MemWrite, SrcSel, JumpSel, trigger, halt;
  logic [31:0] ImmOp, newPC, retired;
  logic [3:0]  ALU_ctrl;
  logic [1:0]  dataType;
  logic [3:0]  en;
  logic [5:0]  rom_idx;

  logic [31:0] rom [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .eq         (eq),
    .pc         (pc),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .regFileWen (regFileWen),
    .ALUSrc     (ALUSrc),
    .ImmOp      (ImmOp),
    .ALU_ctrl   (ALU_ctrl),
    .MemWrite   (MemWrite),
    .dataType   (dataType),
    .SrcSel     (SrcSel),
    .newPC      (newPC),
    .JumpSel    (JumpSel),
    .trigger    (trigger),
    .halt       (halt),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  assign rom_idx = pc[7:2];
  assign instr   = rom[rom_idx];
  assign en      = {regFileWen, MemWrite, SrcSel, JumpSel};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle (outputs settled, away from posedge).
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
    rom[0]  = 32'h0050_0093; // 0x00 addi x1,x0,5
    rom[1]  = 32'h0010_2423; // 0x04 sw   x1,8(x0)
    rom[2]  = 32'h0080_2103; // 0x08 lw   x2,8(x0)
    rom[8]  = 32'h0020_8863; // 0x20 beq  x1,x2,+16
    rom[9]  = 32'h0020_9663; // 0x24 bne  x1,x2,+12
    rom[12] = 32'h0020_8863; // 0x30 beq  x1,x2,+16
    rom[14] = 32'h0000_007F; // 0x38 illegal opcode
    rom[16] = 32'hFF9F_F0EF; // 0x40 jal  x1,-8

    do_reset();
    // ADDI: cycle 1 is FETCH
    check("rst_pc", pc, 32'h0);
    check("rst_retired", retired, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_en", {28'b0, en}, 32'h0);
    check("trigger", {31'b0, trigger}, 32'd1);
    next_cycle();
    check("addi_rs1", {27'b0, rs1}, 32'd0);
    check("addi_rd", {27'b0, rd}, 32'd1);
    check("addi_imm", ImmOp, 32'd5);
    check("addi_alusrc", {31'b0, ALUSrc}, 32'd1);
    check("addi_aluctrl", {28'b0, ALU_ctrl}, 32'h0);
    check("addi_en_c2", {28'b0, en}, 32'h0);
    next_cycle();
    check("addi_en_c3", {28'b0, en}, 32'h0);
    next_cycle();
    check("addi_en_c4", {28'b0, en}, 32'h8);
    next_cycle();
    check("addi_pc", pc, 32'h4);
    check("addi_retired", retired, 32'd1);

    // SW x1,8(x0)
    check("sw_en_c1", {28'b0, en}, 32'h0);
    next_cycle();
    check("sw_imm", ImmOp, 32'd8);
    check("sw_dtype", {30'b0, dataType}, 32'd0);
    check("sw_rs2", {27'b0, rs2}, 32'd1);
    check("sw_alusrc", {31'b0, ALUSrc}, 32'd1);
    check("sw_en_c2", {28'b0, en}, 32'h0);
    next_cycle();
    check("sw_en_c3", {28'b0, en}, 32'h0);
    next_cycle();
    check("sw_en_c4", {28'b0, en}, 32'h4);
    next_cycle();
    check("sw_pc", pc, 32'h8);
    check("sw_retired", retired, 32'd2);

    // LW x2,8(x0)
    next_cycle();
    check("lw_imm", ImmOp, 32'd8);
    check("lw_dtype", {30'b0, dataType}, 32'd0);
    check("lw_rd", {27'b0, rd}, 32'd2);
    next_cycle();
    check("lw_en_c3", {28'b0, en}, 32'h0);
    next_cycle();
    check("lw_en_c4", {28'b0, en}, 32'h0);
    next_cycle();
    check("lw_en_c5", {28'b0, en}, 32'hA);
    next_cycle();
    check("lw_pc", pc, 32'hC);
    check("lw_retired", retired, 32'd3);

    // Five NOPs, 4 cycles each
    repeat (20) next_cycle();
    check("nop_pc", pc, 32'h20);
    check("nop_retired", retired, 32'd8);

    // BEQ not taken (eq=0)
    eq = 1'b0;
    next_cycle();
    check("beq_alusrc", {31'b0, ALUSrc}, 32'd0);
    check("beq_aluctrl", {28'b0, ALU_ctrl}, 32'h1);
    check("beq_en_c2", {28'b0, en}, 32'h0);
    next_cycle();
    check("beq_en_c3", {28'b0, en}, 32'h0);
    next_cycle();
    check("beq_nt_pc", pc, 32'h24);
    check("beq_nt_retired", retired, 32'd9);

    // BNE taken (eq=0)
    next_cycle();
    next_cycle();
    check("bne_en_c3", {28'b0, en}, 32'h0);
    next_cycle();
    check("bne_t_pc", pc, 32'h30);

    // BEQ taken (eq=1)
    next_cycle();
    eq = 1'b1;
    next_cycle();
    next_cycle();
    eq = 1'b0;
    check("beq_t_pc", pc, 32'h40);
    check("beq_t_retired", retired, 32'd11);

    // JAL x1,-8
    check("jal_newpc_c1", newPC, 32'h44);
    next_cycle();
    check("jal_rd", {27'b0, rd}, 32'd1);
    check("jal_en_c2", {28'b0, en}, 32'h0);
    next_cycle();
    check("jal_en_c3", {28'b0, en}, 32'h9);
    check("jal_newpc", newPC, 32'h44);
    next_cycle();
    check("jal_pc", pc, 32'h38);
    check("jal_retired", retired, 32'd12);

    // Illegal opcode -> HALT
    next_cycle();
    check("ill_halt_dec", {31'b0, halt}, 32'd0);
    next_cycle();
    check("ill_halt", {31'b0, halt}, 32'd1);
    check("ill_en", {28'b0, en}, 32'h0);
    repeat (3) next_cycle();
    check("ill_halt_hold", {31'b0, halt}, 32'd1);
    check("ill_pc_hold", pc, 32'h38);
    check("ill_retired_hold", retired, 32'd12);
    check("ill_en_hold", {28'b0, en}, 32'h0);

    do_reset();
    check("halt_clr", {31'b0, halt}, 32'd0);
    check("halt_clr_pc", pc, 32'h0);
    check("halt_clr_retired", retired, 32'd0);

    // Reset during MEM of SW: write suppressed, back to FETCH at RESET_PC
    repeat (4) next_cycle();
    check("mr_sw_pc", pc, 32'h4);
    repeat (3) next_cycle();
    check("mr_mw_before", {31'b0, MemWrite}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_mw_rst", {31'b0, MemWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_pc", pc, 32'h0);
    check("mr_retired", retired, 32'd0);
    check("mr_en", {28'b0, en}, 32'h0);
    repeat (3) next_cycle();
    check("mr_refetch_wen", {28'b0, en}, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
